// File: rtl/decoder_pkg.sv
// Shared decoder-domain types; word is the common 32-bit configuration/data width.
package decoder_pkg;
  typedef logic [31:0] word;
endpackage

// File: rtl/uart_pkg.sv
// UART receive-side types and frame constants.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_sync.sv
// Metastability chain for the asynchronous serial line; STAGES clocks of latency.
// Resets to 1 so a reset never looks like a start edge.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver into a one-entry valid/ready holding register; valid rises SYNC+H+9T+1 clocks after the start edge.
// A byte arriving while the register is full and not being consumed is dropped and flagged as overrun.
module uart_rx
  import uart_pkg::*;
  import decoder_pkg::*;
#(
  parameter int BASE_DIV    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  word                       prescaler,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      frame_err_o,
  output logic                      overrun_o,
  input  logic                      clear_i
);
  localparam int CNT_W = 33 + $clog2(BASE_DIV);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  logic                      rxs;
  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  word                       presc_q, presc_d;
  logic                      rxs_prev_q;
  logic                      valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic [CNT_W-1:0]          bit_t, bit_last, half_last;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (rx_i),
    .q_o     (rxs)
  );

  assign bit_t     = CNT_W'(BASE_DIV) * (CNT_W'(presc_q) + CNT_W'(1));
  assign bit_last  = bit_t - CNT_W'(1);
  assign half_last = (bit_t >> 1) - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    presc_d = presc_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (valid_q && ready_i) valid_d = 1'b0;
    if (clear_i) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Edge, not level: a low stop bit must not look like a new start.
        if (rxs_prev_q && !rxs) begin
          state_d = START;
          presc_d = prescaler;
        end
      end
      START: begin
        if (cnt_q == half_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == bit_last) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(UART_DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == bit_last) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rxs) begin
            ferr_d = 1'b1;
          end else if (valid_q && !ready_i) begin
            ovr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      presc_q    <= '0;
      rxs_prev_q <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      presc_q    <= presc_d;
      rxs_prev_q <= rxs;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the uart transmitter. It consumes the tx line, which is looped back on the board or driven by a host.
- Recovers 8N1 frames, LSB first, at the same prescaler-derived bit rate as the transmitter.
- Presents each received byte in a one-entry holding register with a valid/ready handshake. Flags framing errors and overruns.
- Lets the team run a loopback check of fifo_interleaved + uart and read back the DE/DEAD/DEADBE/DEADBEEF sequences.

Parameters:
- BASE_DIV, 16: clocks per bit at prescaler=0. Must be even and ≥4.
- SYNC_STAGES, 2: number of input synchronizer flops.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous active-low reset.
- prescaler  input  32 (decoder_pkg::word)  bit time = BASE_DIV*(prescaler+1) clocks. Sampled only when idle.
- rx_i  input  1  serial line; idle high.
- data_o  output  8  received byte (holding register).
- valid_o  output  1  holding register full.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
- frame_err_o  output  1  sticky: a stop bit was sampled low.
- overrun_o  output  1  sticky: a byte completed while the holding register was still full.
- clear_i  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (reset_i=0, async): state=IDLE, all counters 0, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0. Synchronizer flops reset to 1 (idle line).
- The line is seen only after SYNC_STAGES flops; call the synchronized value rxs.
- Bit period T = BASE_DIV*(prescaler+1). Half period H = T/2. Prescaler is latched into a 32-bit register on IDLE→START, so changes mid-frame have no effect.
- A cycle counter counts 0..T-1 (or 0..H-1). Its width covers 32-bit prescaler times BASE_DIV, so no wrap within a bit.
- State IDLE: wait for rxs=0 (falling edge) → START, counter cleared.
- State START: at counter=H-1, sample rxs.
  - rxs=1 (glitch): → IDLE, nothing recorded.
  - rxs=0: → DATA, counter cleared, bit index 0.
- State DATA: at counter=T-1 (mid-bit), shift rxs into bit[idx], LSB first.
  - After idx=7 → STOP, counter cleared.
- State STOP: at counter=T-1, sample rxs (the frame commit point).
  - rxs=1: byte is good.
  - rxs=0: set frame_err_o and discard the byte (holding register unchanged).
  - Either way → IDLE. A low stop bit does not retrigger START until rxs returns to 1 and falls again.
- Frame commit, good byte:
  - Holding register empty, or consumed in the same cycle (valid_o && ready_i): load data_o, valid_o=1 on the next edge.
  - Otherwise: keep the old data_o, keep valid_o=1, set overrun_o. The new byte is dropped.
- Handshake: valid_o && ready_i with no simultaneous commit → valid_o=0 next edge. data_o holds its value after consume.
- Latency: valid_o rises SYNC_STAGES + H + 9*T + 1 clocks after rx_i falls (start edge). With defaults and prescaler=0: 2+8+144+1 = 155 clocks.
- Sticky flags:
  - Cleared only by clear_i or reset.
  - If clear_i and a set event occur in the same cycle, set wins.
- Back-to-back frames: after STOP returns to IDLE, a start edge in the next cycle is accepted. There is no dead time beyond H of the stop bit.
- Reset mid-frame: immediately returns to IDLE. The partial byte is lost; no flags are set.

Decomposition:
- decoder_pkg (existing): word.
- New uart_pkg:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t.
  - localparam UART_DATA_BITS=8.
- Sub-module uart_rx_sync: SYNC_STAGES-deep flop chain, resets to 1.

Test Plan:
- Defaults, prescaler=0, ready_i=1, send frame 0xDE → data_o=0xDE, valid_o high for exactly 1 cycle, 155 clocks after start edge, no flags.
- Loopback through fifo_interleaved+uart: write 0xDEADBEEF width 4 → receive in transmit order bytes 0xEF,0xBE,0xAD,0xDE; no errors.
- ready_i=0, send 0x42 then 0x17 back-to-back → data_o stays 0x42, overrun_o=1. Assert ready_i → valid_o falls; clear_i → overrun_o=0.
- Frame 0x55 with stop bit forced low → frame_err_o=1, valid_o stays 0. The next good frame 0xA5 is received correctly.
- Pulse rx_i low for 4 clocks (< H=8) → no frame and no flags; state returns to IDLE.
- prescaler=3 (T=64), send 0x01, assert reset_i low during bit 3 → all outputs 0. A following full 0x80 frame is received correctly.
